// File: rtl/cdr_pkg.sv
// -----------------------------------------------------------------------------
// cdr_pkg
// Shared definitions for the CDR timing loop: the loop-state encoding, the
// default symbol-period limits, the period type used by the symbol counter
// and the divN block, and the period clamp helper.
// -----------------------------------------------------------------------------
package cdr_pkg;

  // Width of the symbol period value shared with the counter and divN.
  localparam int NB_P_W = 6;

  typedef logic [NB_P_W-1:0] nb_p_t;

  // Default nominal, minimum and maximum samples per symbol.
  localparam int NB_P_NOM_DEF = 25;
  localparam int NB_P_MIN_DEF = 22;
  localparam int NB_P_MAX_DEF = 28;

  // Consecutive quiet windows that move ACQUIRE into TRACK.
  localparam int ACQ_QUIET_WINS = 2;

  // Loop state, as reported on o_state.
  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_TRACK   = 2'd1,
    ST_LOCKED  = 2'd2
  } cdr_state_e;

  // Saturate a requested period into the legal [lo, hi] range.
  function automatic nb_p_t clamp_nb_p(input int val, input int lo, input int hi);
    nb_p_t res;
    if (val < lo) begin
      res = nb_p_t'(lo);
    end else if (val > hi) begin
      res = nb_p_t'(hi);
    end else begin
      res = nb_p_t'(val);
    end
    return res;
  endfunction

endpackage

// File: rtl/cdr_vote_acc.sv
// -----------------------------------------------------------------------------
// cdr_vote_acc
// Accumulates early/late phase-detector votes over a window of WIN symbols.
// Ports:
//   clk, rst      : sample clock, synchronous active-high reset
//   en            : one pulse per symbol, early/late valid on this cycle
//   early, late   : phase-detector votes
//   close         : high on the en cycle that completes the window
//   win_sum       : signed vote sum including the current vote; the value
//                   the controller decides on when close is high
// -----------------------------------------------------------------------------
module cdr_vote_acc #(
  parameter int WIN = 8,
  localparam int SW = $clog2(WIN) + 2,
  localparam int CW = $clog2(WIN) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 early,
  input  logic                 late,
  output logic                 close,
  output logic signed [SW-1:0] win_sum
);

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_WIN = CW'(WIN);

  logic signed [SW-1:0] sum_r;
  logic        [CW-1:0] cnt_r;
  logic signed [SW-1:0] vote_s;
  logic        [CW-1:0] cnt_inc_s;

  // Current vote value and the window-complete condition.
  always_comb begin
    vote_s = {SW{1'b0}};
    if (en && early && !late) begin
      vote_s = {{(SW-1){1'b0}}, 1'b1};
    end else if (en && late && !early) begin
      vote_s = {SW{1'b1}};
    end else begin
      vote_s = {SW{1'b0}};
    end
    win_sum   = sum_r + vote_s;
    cnt_inc_s = cnt_r + CNT_ONE;
    close     = en && (cnt_inc_s == CNT_WIN);
  end

  // Running sum and symbol count; both restart after the closing vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r <= {SW{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (close) begin
      sum_r <= {SW{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      sum_r <= win_sum;
      cnt_r <= cnt_inc_s;
    end else begin
      sum_r <= sum_r;
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/cdr_nbp_ctrl.sv
// -----------------------------------------------------------------------------
// cdr_nbp_ctrl
// Loop filter / controller for the CDR symbol counter. Votes are summed per
// window; a strong window produces a one-symbol period correction that is
// loaded at the next frequency-synch point. An ACQUIRE/TRACK/LOCKED machine
// picks the correction step and reports lock.
// Ports:
//   i_clk, i_rst    : sample clock, synchronous active-high reset
//   i_en            : one pulse per symbol, i_early/i_late valid
//   i_early, i_late : phase-detector votes
//   i_en_freq_synch : point where the counter accepts a new period
//   o_nb_P          : period driven to the symbol counter
//   o_adj           : one-cycle pulse when a correction period is loaded
//   o_lock          : loop locked
//   o_state         : 0=ACQUIRE, 1=TRACK, 2=LOCKED
// -----------------------------------------------------------------------------
module cdr_nbp_ctrl
  import cdr_pkg::*;
#(
  parameter int NB_P_NOM  = NB_P_NOM_DEF,
  parameter int NB_P_MIN  = NB_P_MIN_DEF,
  parameter int NB_P_MAX  = NB_P_MAX_DEF,
  parameter int WIN       = 8,
  parameter int THRESH    = 3,
  parameter int STEP_ACQ  = 2,
  parameter int LOCK_WINS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_early,
  input  logic              i_late,
  input  logic              i_en_freq_synch,
  output logic [NB_P_W-1:0] o_nb_P,
  output logic              o_adj,
  output logic              o_lock,
  output logic [1:0]        o_state
);

  localparam int SW = $clog2(WIN) + 2;
  localparam int PW = 8;
  localparam int QW = $clog2(LOCK_WINS + ACQ_QUIET_WINS) + 1;

  localparam logic [SW-1:0] THRESH_W  = SW'(THRESH);
  localparam logic [SW-1:0] THRESH2_W = SW'(2 * THRESH);
  localparam logic [SW-1:0] WIN_W     = SW'(WIN);
  localparam logic [QW-1:0] Q_ONE     = {{(QW-1){1'b0}}, 1'b1};
  localparam logic [QW-1:0] Q_ACQ     = QW'(ACQ_QUIET_WINS);
  localparam logic [QW-1:0] Q_LOCK    = QW'(LOCK_WINS);

  logic                 close_s;
  logic signed [SW-1:0] win_sum_s;
  logic        [SW-1:0] abs_sum_s;
  logic                 quiet_s;
  logic signed [PW-1:0] step_s;
  logic signed [PW-1:0] decision_s;
  logic signed [PW-1:0] pend_eff_s;
  logic        [QW-1:0] qcnt_inc_s;
  nb_p_t                nb_p_corr_s;

  cdr_state_e           state_r;
  logic        [QW-1:0] qcnt_r;
  logic                 lock_r;
  logic signed [PW-1:0] pending_r;
  nb_p_t                nb_p_r;
  logic                 adj_r;

  cdr_vote_acc #(
    .WIN (WIN)
  ) u_vote_acc (
    .clk     (i_clk),
    .rst     (i_rst),
    .en      (i_en),
    .early   (i_early),
    .late    (i_late),
    .close   (close_s),
    .win_sum (win_sum_s)
  );

  // Window decision; a decision made on a synch cycle is applied at that synch.
  always_comb begin
    if (win_sum_s[SW-1]) begin
      abs_sum_s = -win_sum_s;
    end else begin
      abs_sum_s = win_sum_s;
    end
    quiet_s = (abs_sum_s < THRESH_W);

    if (state_r == ST_ACQUIRE) begin
      step_s = PW'(STEP_ACQ);
    end else begin
      step_s = {{(PW-1){1'b0}}, 1'b1};
    end

    decision_s = {PW{1'b0}};
    if (quiet_s) begin
      decision_s = {PW{1'b0}};
    end else if (win_sum_s[SW-1]) begin
      decision_s = -step_s;
    end else begin
      decision_s = step_s;
    end

    if (close_s) begin
      pend_eff_s = decision_s;
    end else begin
      pend_eff_s = pending_r;
    end

    qcnt_inc_s  = qcnt_r + Q_ONE;
    nb_p_corr_s = clamp_nb_p(NB_P_NOM + int'(pend_eff_s), NB_P_MIN, NB_P_MAX);
  end

  // Loop state machine, quiet-window counter and lock flag; stepped at window close.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_ACQUIRE;
      qcnt_r  <= {QW{1'b0}};
      lock_r  <= 1'b0;
    end else if (close_s) begin
      case (state_r)
        ST_ACQUIRE: begin
          if (!quiet_s) begin
            qcnt_r <= {QW{1'b0}};
          end else if (qcnt_inc_s == Q_ACQ) begin
            state_r <= ST_TRACK;
            qcnt_r  <= {QW{1'b0}};
          end else begin
            qcnt_r <= qcnt_inc_s;
          end
        end
        ST_TRACK: begin
          // A window with every vote in one direction means phase is far off.
          if (abs_sum_s == WIN_W) begin
            state_r <= ST_ACQUIRE;
            qcnt_r  <= {QW{1'b0}};
          end else if (!quiet_s) begin
            qcnt_r <= {QW{1'b0}};
          end else if (qcnt_inc_s == Q_LOCK) begin
            state_r <= ST_LOCKED;
            lock_r  <= 1'b1;
            qcnt_r  <= {QW{1'b0}};
          end else begin
            qcnt_r <= qcnt_inc_s;
          end
        end
        ST_LOCKED: begin
          // Single-step corrections are normal jitter; only a large error drops lock.
          if (abs_sum_s >= THRESH2_W) begin
            state_r <= ST_TRACK;
            lock_r  <= 1'b0;
            qcnt_r  <= {QW{1'b0}};
          end else begin
            state_r <= ST_LOCKED;
          end
        end
        default: begin
          state_r <= ST_ACQUIRE;
          qcnt_r  <= {QW{1'b0}};
          lock_r  <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  // Pending correction and period register; a correction lasts one symbol.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending_r <= {PW{1'b0}};
      nb_p_r    <= nb_p_t'(NB_P_NOM);
      adj_r     <= 1'b0;
    end else if (i_en_freq_synch) begin
      pending_r <= {PW{1'b0}};
      if (pend_eff_s != {PW{1'b0}}) begin
        nb_p_r <= nb_p_corr_s;
        adj_r  <= 1'b1;
      end else begin
        nb_p_r <= nb_p_t'(NB_P_NOM);
        adj_r  <= 1'b0;
      end
    end else begin
      pending_r <= pend_eff_s;
      nb_p_r    <= nb_p_r;
      adj_r     <= 1'b0;
    end
  end

  assign o_nb_P  = nb_p_r;
  assign o_adj   = adj_r;
  assign o_lock  = lock_r;
  assign o_state = state_r;

endmodule

// File: tb/tb_cdr_nbp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cdr_nbp_ctrl
// Two controllers share one stimulus stream: one with default limits and one
// with NB_P_MAX=26 to exercise the clamp. Each is compared every cycle against
// an integer reference model, with extra fixed-value checks at key points.
// -----------------------------------------------------------------------------
module tb_cdr_nbp_ctrl;

  localparam int NOM  = 25;
  localparam int PMIN = 22;
  localparam int WINV = 8;
  localparam int THR  = 3;
  localparam int SACQ = 2;
  localparam int LOCKW = 4;
  localparam int SYM  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       early = 1'b0;
  logic       late = 1'b0;
  logic       synch = 1'b0;
  logic [5:0] nbp_a, nbp_b;
  logic       adj_a, adj_b, lock_a, lock_b;
  logic [1:0] st_a, st_b;

  int n_tests = 0;
  int n_fail  = 0;
  int sync_off = 2;

  typedef struct {
    int sum;
    int cnt;
    int st;
    int q;
    int pend;
    int nbp;
    bit adj;
    bit lock;
  } mdl_t;

  mdl_t ma, mb;

  always #5 clk = ~clk;

  cdr_nbp_ctrl dut_a (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_early(early), .i_late(late),
    .i_en_freq_synch(synch), .o_nb_P(nbp_a), .o_adj(adj_a), .o_lock(lock_a),
    .o_state(st_a)
  );

  cdr_nbp_ctrl #(.NB_P_MAX(26)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_early(early), .i_late(late),
    .i_en_freq_synch(synch), .o_nb_P(nbp_b), .o_adj(adj_b), .o_lock(lock_b),
    .o_state(st_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, computed directly from the rules.
  function automatic mdl_t mstep(input mdl_t s, input int pmax, input bit r_in,
                                 input bit e_in, input bit ev, input bit lv,
                                 input bit sy);
    mdl_t r;
    int d, mag, step, want;
    r = s;
    r.adj = 1'b0;
    if (r_in) begin
      r.sum = 0; r.cnt = 0; r.st = 0; r.q = 0; r.pend = 0;
      r.nbp = NOM; r.lock = 1'b0;
      return r;
    end
    d = s.pend;
    if (e_in) begin
      if (ev && !lv) r.sum = s.sum + 1;
      else if (lv && !ev) r.sum = s.sum - 1;
      r.cnt = s.cnt + 1;
      if (r.cnt == WINV) begin
        mag  = (r.sum < 0) ? -r.sum : r.sum;
        step = (s.st == 0) ? SACQ : 1;
        if (r.sum >= THR) d = step;
        else if (r.sum <= -THR) d = -step;
        else d = 0;
        if (s.st == 0) begin
          if (mag < THR) begin
            r.q = s.q + 1;
            if (r.q >= 2) begin r.st = 1; r.q = 0; end
          end else r.q = 0;
        end else if (s.st == 1) begin
          if (mag == WINV) begin
            r.st = 0; r.q = 0;
          end else if (mag < THR) begin
            r.q = s.q + 1;
            if (r.q >= LOCKW) begin r.st = 2; r.lock = 1'b1; r.q = 0; end
          end else r.q = 0;
        end else begin
          if (mag >= 2 * THR) begin r.st = 1; r.lock = 1'b0; r.q = 0; end
        end
        r.sum = 0;
        r.cnt = 0;
      end
    end
    if (sy) begin
      if (d != 0) begin
        want = NOM + d;
        if (want > pmax) want = pmax;
        if (want < PMIN) want = PMIN;
        r.nbp = want;
        r.adj = 1'b1;
      end else begin
        r.nbp = NOM;
      end
      d = 0;
    end
    r.pend = d;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    ma = mstep(ma, 28, rst, en, early, late, synch);
    mb = mstep(mb, 26, rst, en, early, late, synch);
    #1;
    chk("a_nbp", int'(nbp_a), ma.nbp);
    chk("a_adj", int'(adj_a), int'(ma.adj));
    chk("a_lock", int'(lock_a), int'(ma.lock));
    chk("a_state", int'(st_a), ma.st);
    chk("b_nbp", int'(nbp_b), mb.nbp);
    chk("b_adj", int'(adj_b), int'(mb.adj));
    chk("b_lock", int'(lock_b), int'(mb.lock));
    chk("b_state", int'(st_b), mb.st);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; early = 1'b0; late = 1'b0; synch = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic symbol(input bit e, input bit l);
    for (int c = 0; c < SYM; c++) begin
      en    = (c == 0);
      early = (c == 0) && e;
      late  = (c == 0) && l;
      synch = (c == sync_off);
      tick();
    end
    en = 1'b0; early = 1'b0; late = 1'b0; synch = 1'b0;
  endtask

  // ne early votes, then nl late votes, rest of the window silent.
  task automatic window(input int ne, input int nl);
    for (int k = 0; k < WINV; k++) begin
      symbol(k < ne, (k >= ne) && (k < ne + nl));
    end
  endtask

  initial begin
    ma = '{0, 0, 0, 0, 0, NOM, 1'b0, 1'b0};
    mb = ma;

    do_reset();
    chk("rst_nbp", int'(nbp_a), NOM);
    chk("rst_state", int'(st_a), 0);
    chk("rst_lock", int'(lock_a), 0);

    // Quiet acquisition: TRACK after the second quiet window.
    window(0, 0);
    chk("acq_one_quiet", int'(st_a), 0);
    window(0, 0);
    chk("acq_to_track", int'(st_a), 1);

    // ACQUIRE correction, step 2, clamped on the narrow instance.
    do_reset();
    window(8, 0);
    chk("acq_corr_a", int'(nbp_a), 27);
    chk("acq_corr_clamp_b", int'(nbp_b), 26);
    window(0, 0);
    chk("corr_one_period", int'(nbp_a), NOM);
    window(0, 0);
    chk("track_again", int'(st_a), 1);

    // TRACK, all late: step 1 and fall back to ACQUIRE.
    window(0, 8);
    chk("track_full_late_nbp", int'(nbp_a), 24);
    chk("track_full_late_st", int'(st_a), 0);

    // 2 + 4 quiet windows to lock.
    for (int w = 0; w < 6; w++) window(0, 0);
    chk("locked_state", int'(st_a), 2);
    chk("locked_flag", int'(lock_a), 1);

    window(4, 1);
    chk("locked_small_nbp", int'(nbp_a), 26);
    chk("locked_small_keep", int'(lock_a), 1);
    window(7, 0);
    chk("locked_big_state", int'(st_a), 1);
    chk("locked_big_flag", int'(lock_a), 0);

    // Closing vote coincides with the synch point.
    sync_off = 0;
    window(8, 0);
    chk("coinc_nbp", int'(nbp_a), 26);
    chk("coinc_state", int'(st_a), 0);
    sync_off = 2;

    // Reset after 5 votes of a window.
    do_reset();
    for (int k = 0; k < 5; k++) symbol(1'b1, 1'b0);
    do_reset();
    window(0, 0);
    chk("midrst_nbp", int'(nbp_a), NOM);
    chk("midrst_state", int'(st_a), 0);
    window(0, 0);
    chk("midrst_track", int'(st_a), 1);

    // Randomised windows with varying bias and synch phase.
    for (int w = 0; w < 50; w++) begin
      int bias;
      bias = $urandom_range(0, 3);
      for (int k = 0; k < WINV; k++) begin
        bit ev, lv;
        int rv;
        rv = $urandom_range(0, 99);
        case (bias)
          0: begin ev = (rv < 10); lv = (rv >= 90); end
          1: begin ev = (rv < 85); lv = (rv >= 95); end
          2: begin ev = (rv < 5);  lv = (rv >= 15); end
          default: begin ev = rv[0]; lv = rv[1]; end
        endcase
        sync_off = $urandom_range(0, SYM - 1);
        if ($urandom_range(0, 199) == 0) do_reset();
        symbol(ev, lv);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
